// File: rtl/posit_pd_encoder_if.sv
// Decoded-posit bundle: special flags, signed scale, MSB-aligned fraction (hidden bit
// excluded) and the guard/round/sticky bits that sit below the fraction LSB.
interface pd #(
    parameter int    POSIT_WIDTH = 16,
    parameter int    POSIT_ES    = 1,
    parameter string PD_TYPE     = "NORMAL"
);
    localparam int MAX_SCALE = (POSIT_WIDTH - 2) * (2 ** POSIT_ES);
    localparam int SCALE_W   = $clog2(MAX_SCALE + 1) + 2;
    localparam int FRAC_W    = (PD_TYPE == "WIDE") ? 2 * POSIT_WIDTH : POSIT_WIDTH - POSIT_ES - 3;

    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         fraction;
    logic                      sign;
    logic                      zero;
    logic                      nar;
    logic                      guard;
    logic                      round;
    logic                      sticky;

    modport master (output scale, fraction, sign, zero, nar, guard, round, sticky);
    modport slave  (input  scale, fraction, sign, zero, nar, guard, round, sticky);
endinterface

// File: rtl/posit_pd_encoder.sv
// Three-stage posit encoder: classify/clamp, regime+body assembly, RNE round and pack.
// The whole pipe advances on one enable so stalls hold every stage in place.
module posit_pd_encoder #(
    parameter int    POSIT_WIDTH = 16,
    parameter int    POSIT_ES    = 1,
    parameter string PD_TYPE     = "NORMAL"
) (
    input  logic                   clk,
    input  logic                   rst,
    pd.slave                       in_pd,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [POSIT_WIDTH-1:0] out_posit,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int N         = POSIT_WIDTH;
    localparam int ES        = POSIT_ES;
    localparam int MAX_SCALE = (N - 2) * (2 ** ES);
    localparam int SCALE_W   = $clog2(MAX_SCALE + 1) + 2;
    localparam int FRAC_W    = (PD_TYPE == "WIDE") ? 2 * N : N - ES - 3;
    localparam int TW        = ES + FRAC_W + 2;
    localparam int BW        = N + TW;
    localparam int LEN_W     = $clog2(N + 1);

    localparam logic signed [SCALE_W-1:0] MAX_SCALE_S = SCALE_W'(MAX_SCALE);
    localparam logic signed [SCALE_W-1:0] NEG_MAX_S   = SCALE_W'(-MAX_SCALE);
    localparam logic signed [SCALE_W-1:0] ONE_S       = SCALE_W'(1);
    localparam logic [BW-1:0]             TOP_ONE     = {1'b1, {(BW-1){1'b0}}};
    localparam logic [BW-1:0]             ALL_ONES    = {BW{1'b1}};
    localparam logic [N-1:0]              NAR_WORD    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]              MAXPOS_WORD = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]              MINPOS_WORD = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-2:0]              BODY_MAX    = {(N-1){1'b1}};

    typedef enum logic [2:0] {
        SP_NONE   = 3'd0,
        SP_NAR    = 3'd1,
        SP_ZERO   = 3'd2,
        SP_MAXPOS = 3'd3,
        SP_MINPOS = 3'd4
    } special_t;

    logic en_s;

    // stage 1 state
    logic                      v1_r;
    special_t                  sp1_r;
    logic                      sign1_r;
    logic signed [SCALE_W-1:0] k1_r;
    logic [ES-1:0]             e1_r;
    logic [FRAC_W-1:0]         frac1_r;
    logic                      grd1_r;
    logic                      rnd1_r;
    logic                      st1_r;

    // stage 2 state
    logic                      v2_r;
    special_t                  sp2_r;
    logic                      sign2_r;
    logic [N-2:0]              body2_r;
    logic                      g2_r;
    logic                      s2_r;

    special_t                  sp_s;
    logic [SCALE_W-1:0]        len_raw_s;
    logic [LEN_W-1:0]          len_s;
    logic [LEN_W-1:0]          rl_s;
    logic [BW-1:0]             tail_ext_s;
    logic [BW-1:0]             regime_s;
    logic [BW-1:0]             x_s;
    logic [N-2:0]              body_s;
    logic                      g_s;
    logic                      s_s;
    logic                      inc_s;
    logic [N-2:0]              rounded_s;
    logic [N-1:0]              mag_s;
    logic [N-1:0]              posit_s;

    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    // Stage 1 classification: NaR beats zero, out-of-range scales saturate to maxpos/minpos.
    always_comb begin
        sp_s = SP_NONE;
        if (in_pd.nar) begin
            sp_s = SP_NAR;
        end else if (in_pd.zero) begin
            sp_s = SP_ZERO;
        end else if (in_pd.scale > MAX_SCALE_S) begin
            sp_s = SP_MAXPOS;
        end else if (in_pd.scale < NEG_MAX_S) begin
            sp_s = SP_MINPOS;
        end else begin
            sp_s = SP_NONE;
        end
    end

    // Stage 2 assembly: regime pattern on top, {e, fraction, G, R} shifted in below it.
    always_comb begin
        len_raw_s = '0;
        if (k1_r < 0) begin
            len_raw_s = $unsigned(-k1_r);
        end else begin
            len_raw_s = $unsigned(k1_r + ONE_S);
        end
        if (len_raw_s > SCALE_W'(N - 1)) begin
            len_s = LEN_W'(N - 1);
        end else begin
            len_s = len_raw_s[LEN_W-1:0];
        end
        rl_s       = len_s + LEN_W'(1);
        tail_ext_s = {e1_r, frac1_r, grd1_r, rnd1_r, {N{1'b0}}} >> rl_s;
        if (k1_r < 0) begin
            regime_s = TOP_ONE >> len_s;
        end else begin
            regime_s = ~(ALL_ONES >> len_s);
        end
        x_s    = regime_s | tail_ext_s;
        body_s = x_s[BW-1 -: N-1];
        g_s    = x_s[BW-N];
        s_s    = (|x_s[BW-N-1:0]) | st1_r;
    end

    // Stage 3: round-to-nearest-even without wrapping into the sign or collapsing to zero.
    always_comb begin
        inc_s = g2_r & (body2_r[0] | s2_r);
        if (inc_s && (body2_r == BODY_MAX)) begin
            rounded_s = body2_r;
        end else begin
            rounded_s = body2_r + {{(N-2){1'b0}}, inc_s};
        end
        if (rounded_s == {(N-1){1'b0}}) begin
            mag_s = MINPOS_WORD;
        end else begin
            mag_s = {1'b0, rounded_s};
        end
        posit_s = '0;
        case (sp2_r)
            SP_NAR:    posit_s = NAR_WORD;
            SP_ZERO:   posit_s = '0;
            SP_MAXPOS: posit_s = sign2_r ? -MAXPOS_WORD : MAXPOS_WORD;
            SP_MINPOS: posit_s = sign2_r ? -MINPOS_WORD : MINPOS_WORD;
            SP_NONE:   posit_s = sign2_r ? -mag_s : mag_s;
            default:   posit_s = NAR_WORD;
        endcase
    end

    // Valid flags and the output register; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            out_valid <= 1'b0;
            out_posit <= '0;
        end else if (en_s) begin
            v1_r      <= in_valid;
            v2_r      <= v1_r;
            out_valid <= v2_r;
            if (v2_r) begin
                out_posit <= posit_s;
            end
        end
    end

    // Datapath registers for stages 1 and 2, advanced by the same enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp1_r   <= SP_NONE;
            sign1_r <= 1'b0;
            k1_r    <= '0;
            e1_r    <= '0;
            frac1_r <= '0;
            grd1_r  <= 1'b0;
            rnd1_r  <= 1'b0;
            st1_r   <= 1'b0;
            sp2_r   <= SP_NONE;
            sign2_r <= 1'b0;
            body2_r <= '0;
            g2_r    <= 1'b0;
            s2_r    <= 1'b0;
        end else if (en_s) begin
            sp1_r   <= sp_s;
            sign1_r <= in_pd.sign;
            k1_r    <= in_pd.scale >>> ES;
            e1_r    <= in_pd.scale[ES-1:0];
            frac1_r <= in_pd.fraction;
            grd1_r  <= in_pd.guard;
            rnd1_r  <= in_pd.round;
            st1_r   <= in_pd.sticky;
            sp2_r   <= sp1_r;
            sign2_r <= sign1_r;
            body2_r <= body_s;
            g2_r    <= g_s;
            s2_r    <= s_s;
        end
    end
endmodule
